// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time from 4 requesters to a UART serializer, plus a free-running baud divider.
// Grant reaches LOAD one cycle after IDLE sees a request; no new grant while busy, and a request is held until its req_ready pulse.
module uart_tx_arbiter #(
    parameter int CLK_DIV = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        baud_en,
    output logic        tx_senddata,
    output logic [7:0]  tx_byte,
    input  logic        tx_done
);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] baud_cnt;
    logic [1:0]  last_grant;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;
    logic        grant_go;

    // Registered compare: the tick lands the cycle the counter wraps, so the
    // first tick comes exactly CLK_DIV edges after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            baud_en  <= 1'b0;
        end else begin
            baud_en  <= (baud_cnt == DIV_MAX);
            baud_cnt <= (baud_cnt == DIV_MAX) ? '0 : baud_cnt + 16'd1;
        end
    end

    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign grant_go = tx_done && (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (!tx_done) state_nxt = WAIT;
            WAIT:    if (tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        busy        = (state != IDLE);
        tx_senddata = (state == START);
        if (state == LOAD) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Byte and grant are captured on the IDLE->LOAD edge so they are already
    // valid alongside the req_ready pulse, while the requester's data is stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte    <= 8'h00;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
        end else if (state == IDLE && grant_go) begin
            tx_byte    <= req_data[{winner, 3'b000} +: 8];
            grant_id   <= winner;
            last_grant <= winner;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/bytes, negedge monitors pop and compare.
module tb_uart_tx_arbiter;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] b;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        baud_en;
    logic        tx_senddata;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        hold_low = 1'b0;
    logic        ser_idle = 1'b1;

    logic [9:0]  sreg = '0;
    logic [9:0]  rec = '0;
    logic [9:0]  last_frame = '0;
    int          nbits = 0;

    int checks = 0;
    int errors = 0;
    int grants_seen = 0;

    grant_t     exp_grants[$];
    logic [7:0] exp_bytes[$];

    assign tx_done = ser_idle & ~hold_low;

    uart_tx_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .baud_en     (baud_en),
        .tx_senddata (tx_senddata),
        .tx_byte     (tx_byte),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] b);
        grant_t g;
        g.id = id;
        g.b  = b;
        exp_grants.push_back(g);
        exp_bytes.push_back(b);
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grants_seen < n && t < 3000) begin
            cyc(1);
            t++;
        end
        if (grants_seen < n) timeout("wait_grants");
    endtask

    task automatic wait_done(input logic lvl);
        int t = 0;
        while (tx_done !== lvl && t < 3000) begin
            cyc(1);
            t++;
        end
        if (tx_done !== lvl) timeout("wait_done");
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(busy === 1'b0 && tx_done === 1'b1) && t < 3000) begin
            cyc(1);
            t++;
        end
        if (busy !== 1'b0) timeout("wait_idle");
    endtask

    // Grant monitor
    always @(negedge clk) begin
        grant_t g;
        if (rst_n && req_ready != 4'b0) begin
            grants_seen++;
            if (exp_grants.size() == 0) begin
                check("unexpected_req_ready", 32'(req_ready), 32'd0);
            end else begin
                g = exp_grants.pop_front();
                check("req_ready", 32'(req_ready), 32'(4'b0001 << g.id));
                check("grant_id", 32'(grant_id), 32'(g.id));
                check("tx_byte_load", 32'(tx_byte), 32'(g.b));
                check("busy_load", 32'(busy), 32'd1);
            end
        end
    end

    // Serializer model: start bit, 8 data bits LSB first, stop bit, one per baud tick
    always @(negedge clk) begin
        logic [7:0] eb;
        if (ser_idle && !hold_low && tx_senddata) begin
            ser_idle = 1'b0;
            sreg     = {1'b1, tx_byte, 1'b0};
            nbits    = 0;
            if (exp_bytes.size() == 0) begin
                check("unexpected_frame", 32'(tx_byte), 32'hFFFF_FFFF);
            end else begin
                eb = exp_bytes.pop_front();
                check("ser_byte", 32'(tx_byte), 32'(eb));
            end
        end else if (!ser_idle && baud_en) begin
            rec  = {sreg[0], rec[9:1]};
            sreg = sreg >> 1;
            nbits++;
            if (nbits == 10) begin
                ser_idle   = 1'b1;
                last_frame = rec;
            end
        end
    end

    initial begin
        int base;
        logic prev_busy;

        // Reset values, serializer stuck busy, requester 1 pending
        rst_n     = 1'b0;
        hold_low  = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_1100;
        cyc(3);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_baud_en", 32'(baud_en), 32'd0);
        check("rst_senddata", 32'(tx_senddata), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("baud_en_edge%0d", k), 32'(baud_en), (k % 4 == 0) ? 32'd1 : 32'd0);
            check("busy_while_done_low", 32'(busy), 32'd0);
        end

        hold_low = 1'b0;
        push(2'd1, 8'h11);
        wait_grants(1);
        req_valid = 4'b0000;
        wait_idle();

        // Single byte 0x55, valid dropped right after acceptance
        req_data  = 32'h0000_0055;
        req_valid = 4'b0001;
        push(2'd0, 8'h55);
        wait_grants(2);
        req_valid = 4'b0000;
        wait_done(1'b0);
        prev_busy = busy;
        while (tx_done !== 1'b1 && prev_busy === 1'b1) begin
            prev_busy = busy;
            cyc(1);
        end
        check("busy_before_done", 32'(prev_busy), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("line_frame_55", 32'(last_frame), 32'h2AA);
        cyc(12);
        check("stay_idle", 32'(busy), 32'd0);
        check("tx_byte_held", 32'(tx_byte), 32'h55);

        // Fresh reset, all four requesters held valid
        rst_n = 1'b0;
        cyc(2);
        rst_n     = 1'b1;
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'b1111;
        push(2'd0, 8'hA0);
        push(2'd1, 8'hA1);
        push(2'd2, 8'hA2);
        push(2'd3, 8'hA3);
        push(2'd0, 8'hA0);
        wait_grants(grants_seen + 5);
        req_valid = 4'b0000;
        wait_idle();

        // Reset while in WAIT; requester 2 re-granted once
        base      = grants_seen;
        req_data  = 32'h003C_0000;
        req_valid = 4'b0100;
        push(2'd2, 8'h3C);
        wait_grants(base + 1);
        wait_done(1'b0);
        cyc(2);
        check("in_wait_busy", 32'(busy), 32'd1);
        check("in_wait_senddata", 32'(tx_senddata), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_baud_en", 32'(baud_en), 32'd0);
        check("midrst_senddata", 32'(tx_senddata), 32'd0);
        check("midrst_tx_byte", 32'(tx_byte), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        push(2'd2, 8'h3C);
        cyc(2);
        check("no_load_while_ser_busy", 32'(busy), 32'd0);
        wait_grants(base + 2);
        req_valid = 4'b0000;
        wait_idle();
        cyc(10);
        check("grant_count", 32'(grants_seen - base), 32'd2);

        check("grants_left", 32'(exp_grants.size()), 32'd0);
        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 104, SHALL set clk cycles per baud tick; legal range 2..65535.
REQ-002 clk  input  1  single clock for all logic; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  4  per-requester byte-pending flag; bit i = requester i.
REQ-005 req_data  input  32  requester i byte on bits [8i+7:8i]; held stable while req_valid[i]=1.
REQ-006 req_ready  output  4  one-cycle pulse on bit i when requester i's byte is accepted.
REQ-007 grant_id  output  2  index of the requester whose byte is in flight.
REQ-008 busy  output  1  high from acceptance until the serializer reports done.
REQ-009 baud_en  output  1  baud-tick enable to the serializer en input.
REQ-010 tx_senddata  output  1  start request to the serializer.
REQ-011 tx_byte  output  8  byte presented to the serializer.
REQ-012 tx_done  input  1  serializer done/idle flag; high = idle.

Function
REQ-013 Baud counter SHALL count 0..CLK_DIV-1 free-running, independent of arbiter state.
REQ-014 baud_en SHALL be high for exactly one clk cycle when the counter equals CLK_DIV-1, else low.
REQ-015 FSM states SHALL be IDLE, LOAD, START and WAIT.
REQ-016 IDLE: when tx_done=1 and any req_valid bit is set, the FSM SHALL select a requester and go to LOAD next cycle; otherwise it stays in IDLE.
REQ-017 Selection SHALL be round-robin: search order starts at last_grant+1 mod 4; the first set req_valid bit wins.
REQ-018 LOAD (one cycle): the FSM SHALL latch req_data of the winner into tx_byte, set grant_id and last_grant, pulse req_ready[winner], then go to START.
REQ-019 START: tx_senddata SHALL be held high and tx_byte held stable; when tx_done=0 is sampled, tx_senddata SHALL drop next cycle and the FSM SHALL go to WAIT.
REQ-020 WAIT: when tx_done=1 is sampled, the FSM SHALL return to IDLE; the earliest next LOAD is the following cycle.
REQ-021 busy SHALL be high in LOAD, START and WAIT, and low in IDLE.
REQ-022 At most one req_ready bit SHALL be high in any cycle, and only in LOAD.
REQ-023 req_valid changes outside IDLE SHALL be ignored; a requester dropping valid after acceptance SHALL NOT affect the in-flight byte.
REQ-024 With a single requester continuously valid, it SHALL be granted back-to-back with no starvation check needed; with all 4 valid, grants SHALL cycle 0,1,2,3,0...
REQ-025 tx_byte SHALL hold its value after a frame until the next LOAD.

Reset
REQ-026 While rst_n=0: FSM=IDLE, baud counter=0, baud_en=0, tx_senddata=0, tx_byte=0x00, req_ready=0, busy=0, grant_id=0, last_grant=3 (requester 0 has first priority).
REQ-027 Reset mid-frame SHALL abandon the byte with no req_ready re-pulse.
REQ-028 The serializer is not reset; after reset release, the FSM SHALL NOT leave IDLE until tx_done=1 is sampled.
REQ-029 baud_en SHALL first assert CLK_DIV cycles after rst_n deasserts.

Verification
REQ-030 CLK_DIV=4, reset release -> baud_en pulses in cycles 4, 8, 12... after release, each 1 cycle wide.
REQ-031 req_valid=0001, req_data[7:0]=0x55, serializer attached -> req_ready=0001 for one cycle; line carries start bit, then bits 1,0,1,0,1,0,1,0, then stop bit; busy falls after tx_done returns to 1.
REQ-032 req_valid=1111 held, bytes 0xA0..0xA3 -> grant_id sequence 0,1,2,3,0 and req_ready one-hot in the matching order.
REQ-033 tx_done forced to 0 at reset release, req_valid=0010 -> no LOAD until tx_done=1, then grant_id=1.
REQ-034 rst_n pulsed low while in WAIT with req_valid=0100 -> all outputs return to reset values immediately; after tx_done=1, requester 2 is re-granted with exactly one new req_ready pulse.
REQ-035 req_valid=0001 dropped to 0 in the cycle after its req_ready pulse -> in-flight byte completes unchanged, and the FSM then stays in IDLE.
